// File: rtl/irq_request_sequencer_pkg.sv
// irq_seq_pkg: shared sizes, FSM states and grant decoding helpers
// for the interrupt request sequencer.
package irq_seq_pkg;
    localparam int NCH   = 9;
    localparam int NLVL  = 3;
    localparam int NREQ  = NCH * NLVL;
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, PRESENT, CLEAR} state_t;

    function automatic logic [IDX_W-1:0] idx(input logic [1:0] lvl, input logic [3:0] ch);
        return IDX_W'(int'(lvl) * NCH + int'(ch));
    endfunction

    // Range checks short-circuit before the request vector is indexed.
    function automatic logic legal(input logic [1:0] lvl, input logic [3:0] ch,
                                   input logic [NREQ-1:0] req);
        return (int'(lvl) < NLVL) && (int'(ch) < NCH) && req[idx(lvl, ch)];
    endfunction
endpackage

// File: rtl/irq_request_sequencer_if.sv
// irq_request_sequencer_if: event/request, grant and CPU handshake signals;
// slave is the sequencer side, master is the environment side.
interface irq_request_sequencer_if;
    import irq_seq_pkg::*;
    logic [NREQ-1:0] evt_i;
    logic [NREQ-1:0] mask_i;
    logic [NREQ-1:0] req_o;
    logic            gnt_valid_i;
    logic [1:0]      gnt_lvl_i;
    logic [3:0]      gnt_ch_i;
    logic            irq_o;
    logic [1:0]      irq_lvl_o;
    logic [3:0]      irq_ch_o;
    logic            irq_ack_i;
    logic            err_o;
    logic            busy_o;

    modport slave (
        input  evt_i, mask_i, gnt_valid_i, gnt_lvl_i, gnt_ch_i, irq_ack_i,
        output req_o, irq_o, irq_lvl_o, irq_ch_o, err_o, busy_o
    );
    modport master (
        output evt_i, mask_i, gnt_valid_i, gnt_lvl_i, gnt_ch_i, irq_ack_i,
        input  req_o, irq_o, irq_lvl_o, irq_ch_o, err_o, busy_o
    );
endinterface

// File: rtl/irq_request_sequencer_pending_bank.sv
// irq_pending_bank: rising-edge capture into pending latches with
// set-wins clearing, and the registered masked request vector.
module irq_pending_bank
    import irq_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  evt_i,
    input  logic [NREQ-1:0]  mask_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    output logic [NREQ-1:0]  req_o
);
    logic [NREQ-1:0] evt_q, pend_q, pend_d, clr;

    assign clr    = clr_en_i ? NREQ'(1) << clr_idx_i : '0;
    assign pend_d = (pend_q & ~clr) | (evt_i & ~evt_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q  <= '0;
            pend_q <= '0;
            req_o  <= '0;
        end else begin
            evt_q  <= evt_i;
            pend_q <= pend_d;
            req_o  <= pend_q & ~mask_i;
        end
    end
endmodule

// File: rtl/irq_request_sequencer.sv
// irq_request_sequencer: accepts controller grants and runs the
// interrupt/acknowledge handshake with timeout towards the CPU.
module irq_request_sequencer
    import irq_seq_pkg::*;
#(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    irq_request_sequencer_if.slave  bus
);
    state_t             state_q;
    logic [TMO_W-1:0]   cnt_q;
    logic               irq_q, err_q;
    logic [1:0]         lvl_q;
    logic [3:0]         ch_q;

    irq_pending_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_i     (bus.evt_i),
        .mask_i    (bus.mask_i),
        .clr_en_i  (state_q == CLEAR),
        .clr_idx_i (idx(lvl_q, ch_q)),
        .req_o     (bus.req_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
            lvl_q   <= '0;
            ch_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.gnt_valid_i) begin
                    if (legal(bus.gnt_lvl_i, bus.gnt_ch_i, bus.req_o)) begin
                        lvl_q   <= bus.gnt_lvl_i;
                        ch_q    <= bus.gnt_ch_i;
                        irq_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= PRESENT;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                // Acknowledge is checked first so it wins over a coincident timeout.
                PRESENT: if (bus.irq_ack_i) begin
                    irq_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= CLEAR;
                end else if (cnt_q == TMO_W'(TMO_MAX - 1)) begin
                    irq_q   <= 1'b0;
                    err_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + TMO_W'(1);
                end
                CLEAR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.irq_o     = irq_q;
    assign bus.irq_lvl_o = lvl_q;
    assign bus.irq_ch_o  = ch_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_irq_request_sequencer.sv
// tb_irq_request_sequencer: directed scenarios then random traffic,
// each cycle checked against a bit-array reference model.
module tb_irq_request_sequencer;
    localparam int N = 27;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    irq_request_sequencer_if bus();

    irq_request_sequencer #(.TMO_W(8), .TMO_MAX(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one flag per request line plus a service record.
    bit m_pend[N], m_req[N], m_prev[N];
    bit m_serving, m_clearing, m_err;
    int m_lvl, m_ch, m_age;

    task automatic model_edge();
        bit np[N], nr[N];
        if (!rst_n) begin
            foreach (m_pend[i]) begin
                m_pend[i] = 0; m_req[i] = 0; m_prev[i] = 0;
            end
            m_serving = 0; m_clearing = 0; m_err = 0;
            m_lvl = 0; m_ch = 0; m_age = 0;
            return;
        end
        foreach (np[i]) begin
            np[i] = (m_pend[i] && !(m_clearing && i == m_lvl * 9 + m_ch))
                    || (bus.evt_i[i] && !m_prev[i]);
            nr[i] = m_pend[i] && !bus.mask_i[i];
        end
        if (m_clearing) m_clearing = 0;
        else if (m_serving) begin
            if (bus.irq_ack_i) begin
                m_serving = 0; m_clearing = 1;
            end else if (m_age == TMO - 1) begin
                m_serving = 0; m_err = 1;
            end else m_age++;
        end else if (bus.gnt_valid_i) begin
            if (bus.gnt_lvl_i < 3 && bus.gnt_ch_i < 9 && m_req[bus.gnt_lvl_i * 9 + bus.gnt_ch_i]) begin
                m_serving = 1; m_lvl = bus.gnt_lvl_i; m_ch = bus.gnt_ch_i; m_age = 0;
            end else m_err = 1;
        end
        foreach (np[i]) begin
            m_pend[i] = np[i]; m_req[i] = nr[i]; m_prev[i] = bus.evt_i[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] er;
        foreach (m_req[i]) er[i] = m_req[i];
        chk("req_o", 32'(bus.req_o), 32'(er));
        chk("irq_o", 32'(bus.irq_o), 32'(m_serving));
        chk("irq_lvl_o", 32'(bus.irq_lvl_o), 32'(m_lvl));
        chk("irq_ch_o", 32'(bus.irq_ch_o), 32'(m_ch));
        chk("err_o", 32'(bus.err_o), 32'(m_err));
        chk("busy_o", 32'(bus.busy_o), 32'(m_serving || m_clearing));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic grant(input int l, input int c);
        bus.gnt_valid_i = 1'b1;
        bus.gnt_lvl_i = 2'(l);
        bus.gnt_ch_i = 4'(c);
        step();
        bus.gnt_valid_i = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse13();
        bus.evt_i[13] = 1'b1;
        step();
        bus.evt_i[13] = 1'b0;
        step();
    endtask

    initial begin
        bus.evt_i = '0; bus.mask_i = '0; bus.gnt_valid_i = 0;
        bus.gnt_lvl_i = 0; bus.gnt_ch_i = 0; bus.irq_ack_i = 0;
        step(); step();
        chk("reset_req", 32'(bus.req_o), 0);
        chk("reset_busy", 32'(bus.busy_o), 0);
        rst_n = 1'b1;

        // Edge on line 13 reaches req_o one register after pending.
        pulse13();
        chk("req13_up", 32'(bus.req_o), 32'(1) << 13);
        step();

        grant(1, 4);
        chk("gnt_irq", 32'(bus.irq_o), 1);
        chk("gnt_lvl", 32'(bus.irq_lvl_o), 1);
        chk("gnt_ch", 32'(bus.irq_ch_o), 4);
        repeat (5) step();
        ack();
        chk("clear_irq", 32'(bus.irq_o), 0);
        chk("clear_busy", 32'(bus.busy_o), 1);
        step();
        chk("idle_busy", 32'(bus.busy_o), 0);
        chk("req13_lag", 32'(bus.req_o[13]), 1);
        step();
        chk("req13_drop", 32'(bus.req_o[13]), 0);

        grant(3, 2);
        chk("ill_lvl_err", 32'(bus.err_o), 1);
        chk("ill_lvl_irq", 32'(bus.irq_o), 0);
        do_reset();
        grant(0, 11);
        chk("ill_ch_err", 32'(bus.err_o), 1);
        chk("ill_ch_busy", 32'(bus.busy_o), 0);
        do_reset();
        grant(2, 0);
        chk("ill_noreq_err", 32'(bus.err_o), 1);
        step();
        chk("err_sticky", 32'(bus.err_o), 1);
        do_reset();

        // Timeout with no acknowledge.
        pulse13(); step();
        grant(1, 4);
        repeat (TMO - 1) step();
        chk("tmo_irq_hold", 32'(bus.irq_o), 1);
        step();
        chk("tmo_irq_drop", 32'(bus.irq_o), 0);
        chk("tmo_err", 32'(bus.err_o), 1);
        chk("tmo_req_kept", 32'(bus.req_o[13]), 1);
        do_reset();

        // Acknowledge on the timeout cycle wins.
        pulse13(); step();
        grant(1, 4);
        repeat (TMO - 1) step();
        ack();
        chk("ackwin_err", 32'(bus.err_o), 0);
        chk("ackwin_busy", 32'(bus.busy_o), 1);
        step(); step();

        // New edge during CLEAR keeps the bit pending.
        pulse13(); step();
        grant(1, 4);
        step();
        ack();
        bus.evt_i[13] = 1'b1;
        step();
        bus.evt_i[13] = 1'b0;
        step(); step();
        chk("setwins_req", 32'(bus.req_o[13]), 1);

        bus.mask_i[13] = 1'b1;
        step();
        chk("mask_req", 32'(bus.req_o[13]), 0);
        step();
        bus.mask_i[13] = 1'b0;
        step();
        chk("unmask_req", 32'(bus.req_o[13]), 1);

        grant(1, 4);
        step();
        do_reset();
        chk("rst_irq", 32'(bus.irq_o), 0);
        chk("rst_req", 32'(bus.req_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        step();

        for (int k = 0; k < 1500; k++) begin
            bus.evt_i ^= 27'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) bus.mask_i = 27'($urandom & $urandom);
            bus.gnt_valid_i = $urandom_range(0, 3) == 0;
            bus.gnt_lvl_i = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.gnt_ch_i = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            bus.irq_ack_i = $urandom_range(0, 5) == 0;
            rst_n = $urandom_range(0, 199) != 0;
            step();
        end
        rst_n = 1'b1;
        bus.gnt_valid_i = 0;
        bus.irq_ack_i = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
